// File: rtl/rggen_rtl_pkg.sv
// Shared types and helpers for the rggen interrupt coalescer.
// The saturating add operates at 32 bits; callers cast operands in and results out.
package rggen_rtl_pkg;

    typedef enum logic [1:0] {
        RGGEN_IRQ_IDLE,
        RGGEN_IRQ_WAIT,
        RGGEN_IRQ_ASSERT
    } rggen_irq_state;

    function automatic logic [31:0] rggen_sat_add(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [31:0] max_value
    );
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, max_value}) begin
            return max_value;
        end
        return sum[31:0];
    endfunction

endpackage

// File: rtl/rggen_irq_coalescer_if.sv
// Status/config inputs and interrupt outputs of the coalescer, grouped as one bus.
interface rggen_irq_coalescer_if #(
    parameter int WIDTH       = 8,
    parameter int COUNT_WIDTH = 8,
    parameter int TIMER_WIDTH = 16
);
    logic [WIDTH-1:0]       i_status;
    logic [WIDTH-1:0]       i_enable;
    logic [COUNT_WIDTH-1:0] i_threshold;
    logic [TIMER_WIDTH-1:0] i_timeout;
    logic                   o_irq;
    logic [COUNT_WIDTH-1:0] o_event_count;
    logic                   o_busy;

    modport master (
        output i_status, i_enable, i_threshold, i_timeout,
        input  o_irq, o_event_count, o_busy
    );

    modport slave (
        input  i_status, i_enable, i_threshold, i_timeout,
        output o_irq, o_event_count, o_busy
    );
endinterface

// File: rtl/rggen_popcount.sv
// Combinational population count of a bit vector.
module rggen_popcount #(
    parameter int WIDTH     = 8,
    parameter int OUT_WIDTH = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0]     in_bits,
    output logic [OUT_WIDTH-1:0] ones
);
    always_comb begin
        ones = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ones = ones + OUT_WIDTH'(in_bits[i]);
        end
    end
endmodule

// File: rtl/rggen_irq_coalescer.sv
// Interrupt coalescer: counts newly raised enabled status bits and fires one
// registered irq on count threshold or wait timeout, held until all pending clear.
//   state  | meaning
//   IDLE   | nothing pending, counter and timer cleared
//   WAIT   | events pending, accumulating toward threshold or timeout
//   ASSERT | irq raised, held until every enabled pending bit clears
module rggen_irq_coalescer
    import rggen_rtl_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int COUNT_WIDTH = 8,
    parameter int TIMER_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rggen_irq_coalescer_if.slave  bus
);
    localparam int RISE_WIDTH = $clog2(WIDTH + 1);
    localparam int TW1        = TIMER_WIDTH + 1;
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [TIMER_WIDTH-1:0] TMR_MAX = '1;

    rggen_irq_state         state_q, state_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [TIMER_WIDTH-1:0] timer_q, timer_d;
    logic [WIDTH-1:0]       prev_q;
    logic                   irq_q;

    logic [WIDTH-1:0]       pending;
    logic [WIDTH-1:0]       rise;
    logic [RISE_WIDTH-1:0]  n_rise;
    logic [COUNT_WIDTH-1:0] thr;
    logic [COUNT_WIDTH-1:0] cnt_next;
    logic [COUNT_WIDTH-1:0] cnt_first;
    logic [TIMER_WIDTH-1:0] timer_inc;
    logic                   tmo_hit;

    assign pending = bus.i_status & bus.i_enable;
    // prev_q follows pending every cycle, so enabling an already-set bit is a rise
    assign rise    = pending & ~prev_q;

    rggen_popcount #(
        .WIDTH     (WIDTH),
        .OUT_WIDTH (RISE_WIDTH)
    ) u_popcount (
        .in_bits (rise),
        .ones    (n_rise)
    );

    assign thr       = (bus.i_threshold == '0) ? COUNT_WIDTH'(1) : bus.i_threshold;
    assign cnt_next  = COUNT_WIDTH'(rggen_sat_add(32'(cnt_q), 32'(n_rise), 32'(CNT_MAX)));
    assign cnt_first = COUNT_WIDTH'(rggen_sat_add(32'd0, 32'(n_rise), 32'(CNT_MAX)));
    assign timer_inc = TIMER_WIDTH'(rggen_sat_add(32'(timer_q), 32'd1, 32'(TMR_MAX)));
    assign tmo_hit   = (bus.i_timeout != '0) &&
                       (({1'b0, timer_q} + TW1'(1)) >= {1'b0, bus.i_timeout});

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        timer_d = timer_q;
        case (state_q)
            RGGEN_IRQ_IDLE: begin
                timer_d = '0;
                if (pending != '0) begin
                    cnt_d   = cnt_first;
                    state_d = (cnt_first >= thr) ? RGGEN_IRQ_ASSERT : RGGEN_IRQ_WAIT;
                end else begin
                    cnt_d = '0;
                end
            end
            RGGEN_IRQ_WAIT: begin
                // Clearing takes priority over any fire condition in the same cycle
                if (pending == '0) begin
                    state_d = RGGEN_IRQ_IDLE;
                    cnt_d   = '0;
                    timer_d = '0;
                end else begin
                    cnt_d   = cnt_next;
                    timer_d = timer_inc;
                    if ((cnt_next >= thr) || tmo_hit) begin
                        state_d = RGGEN_IRQ_ASSERT;
                    end
                end
            end
            RGGEN_IRQ_ASSERT: begin
                if (pending == '0) begin
                    state_d = RGGEN_IRQ_IDLE;
                    cnt_d   = '0;
                    timer_d = '0;
                end else begin
                    cnt_d = cnt_next;
                end
            end
            default: begin
                state_d = RGGEN_IRQ_IDLE;
                cnt_d   = '0;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RGGEN_IRQ_IDLE;
            cnt_q   <= '0;
            timer_q <= '0;
            prev_q  <= '0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
            prev_q  <= pending;
            irq_q   <= (state_d == RGGEN_IRQ_ASSERT);
        end
    end

    assign bus.o_irq         = irq_q;
    assign bus.o_event_count = cnt_q;
    assign bus.o_busy        = (state_q != RGGEN_IRQ_IDLE);

endmodule

// File: tb/tb_rggen_irq_coalescer.sv
// Scoreboard bench for rggen_irq_coalescer: directed steps push expected
// outputs, per-DUT monitors pop and compare one cycle later.
module tb_rggen_irq_coalescer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    rggen_irq_coalescer_if #(.WIDTH(8), .COUNT_WIDTH(8), .TIMER_WIDTH(16)) bus_a ();
    rggen_irq_coalescer_if #(.WIDTH(8), .COUNT_WIDTH(2), .TIMER_WIDTH(16)) bus_b ();

    rggen_irq_coalescer #(.WIDTH(8), .COUNT_WIDTH(8), .TIMER_WIDTH(16)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    rggen_irq_coalescer #(.WIDTH(8), .COUNT_WIDTH(2), .TIMER_WIDTH(16)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    typedef struct {
        string      name;
        logic       irq;
        logic [7:0] cnt;
        logic       busy;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int vectors = 0;
    int miscompares = 0;

    task automatic compare(input string name, input exp_t e,
                           input logic irq, input logic [7:0] cnt, input logic busy);
        vectors++;
        if (irq !== e.irq || cnt !== e.cnt || busy !== e.busy) begin
            miscompares++;
            $display("FAIL %s: got irq=%0b cnt=%0d busy=%0b, expected irq=%0b cnt=%0d busy=%0b",
                     name, irq, cnt, busy, e.irq, e.cnt, e.busy);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q_a.size() != 0) begin
                e = q_a.pop_front();
                compare(e.name, e, bus_a.o_irq, bus_a.o_event_count, bus_a.o_busy);
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q_b.size() != 0) begin
                e = q_b.pop_front();
                compare(e.name, e, bus_b.o_irq, {6'b0, bus_b.o_event_count}, bus_b.o_busy);
            end
        end
    end

    task automatic step_a(input string name, input logic [7:0] st, input logic [7:0] en,
                          input logic [7:0] thr, input logic [15:0] tmo,
                          input logic irq, input logic [7:0] cnt, input logic busy);
        exp_t e;
        @(negedge clk);
        bus_a.i_status    = st;
        bus_a.i_enable    = en;
        bus_a.i_threshold = thr;
        bus_a.i_timeout   = tmo;
        e = '{name, irq, cnt, busy};
        q_a.push_back(e);
    endtask

    task automatic step_b(input string name, input logic [7:0] st,
                          input logic irq, input logic [7:0] cnt, input logic busy);
        exp_t e;
        @(negedge clk);
        bus_b.i_status    = st;
        bus_b.i_enable    = 8'hFF;
        bus_b.i_threshold = 2'd0;
        bus_b.i_timeout   = 16'd0;
        e = '{name, irq, cnt, busy};
        q_b.push_back(e);
    endtask

    initial begin
        exp_t e;
        bus_a.i_status = '0; bus_a.i_enable = '0; bus_a.i_threshold = '0; bus_a.i_timeout = '0;
        bus_b.i_status = '0; bus_b.i_enable = '0; bus_b.i_threshold = '0; bus_b.i_timeout = '0;

        #2;
        e = '{"reset_a", 1'b0, 8'd0, 1'b0};
        compare(e.name, e, bus_a.o_irq, bus_a.o_event_count, bus_a.o_busy);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Test 1: thr=1, single bit, then a second rise while asserted
        step_a("t1_idle",    8'h00, 8'hFF, 8'd1, 16'd0, 1'b0, 8'd0, 1'b0);
        step_a("t1_fire",    8'h01, 8'hFF, 8'd1, 16'd0, 1'b1, 8'd1, 1'b1);
        step_a("t1_hold",    8'h01, 8'hFF, 8'd1, 16'd0, 1'b1, 8'd1, 1'b1);
        step_a("t1_rerise",  8'h03, 8'hFF, 8'd1, 16'd0, 1'b1, 8'd2, 1'b1);
        step_a("t1_clear",   8'h00, 8'hFF, 8'd1, 16'd0, 1'b0, 8'd0, 1'b0);

        // Test 2: thr=3, rises two cycles apart
        step_a("t2_r0",      8'h01, 8'hFF, 8'd3, 16'd0, 1'b0, 8'd1, 1'b1);
        step_a("t2_w0",      8'h01, 8'hFF, 8'd3, 16'd0, 1'b0, 8'd1, 1'b1);
        step_a("t2_r1",      8'h03, 8'hFF, 8'd3, 16'd0, 1'b0, 8'd2, 1'b1);
        step_a("t2_w1",      8'h03, 8'hFF, 8'd3, 16'd0, 1'b0, 8'd2, 1'b1);
        step_a("t2_r2",      8'h07, 8'hFF, 8'd3, 16'd0, 1'b1, 8'd3, 1'b1);
        step_a("t2_hold",    8'h07, 8'hFF, 8'd3, 16'd0, 1'b1, 8'd3, 1'b1);
        step_a("t2_clear",   8'h00, 8'hFF, 8'd3, 16'd0, 1'b0, 8'd0, 1'b0);

        // Test 3: timeout 5 fires after five cycles in WAIT
        step_a("t3_enter",   8'h08, 8'hFF, 8'd4, 16'd5, 1'b0, 8'd1, 1'b1);
        for (int i = 0; i < 4; i++)
            step_a("t3_wait", 8'h08, 8'hFF, 8'd4, 16'd5, 1'b0, 8'd1, 1'b1);
        step_a("t3_tmo",     8'h08, 8'hFF, 8'd4, 16'd5, 1'b1, 8'd1, 1'b1);
        step_a("t3_clear",   8'h00, 8'hFF, 8'd4, 16'd5, 1'b0, 8'd0, 1'b0);

        // Test 4: enable opens on already-set status bits
        step_a("t4_masked",  8'h0F, 8'h00, 8'd4, 16'd0, 1'b0, 8'd0, 1'b0);
        step_a("t4_masked2", 8'h0F, 8'h00, 8'd4, 16'd0, 1'b0, 8'd0, 1'b0);
        step_a("t4_enable",  8'h0F, 8'h0F, 8'd4, 16'd0, 1'b1, 8'd4, 1'b1);
        step_a("t4_hold",    8'h0F, 8'h0F, 8'd4, 16'd0, 1'b1, 8'd4, 1'b1);
        step_a("t4_clear",   8'h00, 8'h0F, 8'd4, 16'd0, 1'b0, 8'd0, 1'b0);

        // Test 5: rise and partial clear together, then fire-with-clear
        step_a("t5_r0",      8'h01, 8'hFF, 8'd3, 16'd0, 1'b0, 8'd1, 1'b1);
        step_a("t5_r1",      8'h03, 8'hFF, 8'd3, 16'd0, 1'b0, 8'd2, 1'b1);
        step_a("t5_swap",    8'h20, 8'hFF, 8'd3, 16'd0, 1'b1, 8'd3, 1'b1);
        step_a("t5_clear",   8'h00, 8'hFF, 8'd3, 16'd0, 1'b0, 8'd0, 1'b0);
        step_a("t5_enter",   8'h01, 8'hFF, 8'd3, 16'd0, 1'b0, 8'd1, 1'b1);
        step_a("t5_thrclr",  8'h00, 8'hFF, 8'd1, 16'd0, 1'b0, 8'd0, 1'b0);
        step_a("t5_enter2",  8'h02, 8'hFF, 8'd3, 16'd1, 1'b0, 8'd1, 1'b1);
        step_a("t5_tmoclr",  8'h00, 8'hFF, 8'd3, 16'd1, 1'b0, 8'd0, 1'b0);

        // Threshold and timeout changes while waiting
        step_a("thr_enter",  8'h01, 8'hFF, 8'd5, 16'd0, 1'b0, 8'd1, 1'b1);
        step_a("thr_lower",  8'h01, 8'hFF, 8'd1, 16'd0, 1'b1, 8'd1, 1'b1);
        step_a("thr_clear",  8'h00, 8'hFF, 8'd1, 16'd0, 1'b0, 8'd0, 1'b0);
        step_a("tmo_enter",  8'h01, 8'hFF, 8'd8, 16'd0, 1'b0, 8'd1, 1'b1);
        step_a("tmo_set3",   8'h01, 8'hFF, 8'd8, 16'd3, 1'b0, 8'd1, 1'b1);
        step_a("tmo_set2",   8'h01, 8'hFF, 8'd8, 16'd2, 1'b1, 8'd1, 1'b1);
        step_a("tmo_clear",  8'h00, 8'hFF, 8'd8, 16'd2, 1'b0, 8'd0, 1'b0);

        // Test 6: two-bit counter saturates, then async reset mid-ASSERT
        step_b("t6_fire",    8'h01, 1'b1, 8'd1, 1'b1);
        step_b("t6_c2",      8'h03, 1'b1, 8'd2, 1'b1);
        step_b("t6_c3",      8'h07, 1'b1, 8'd3, 1'b1);
        step_b("t6_sat4",    8'h0F, 1'b1, 8'd3, 1'b1);
        step_b("t6_sat5",    8'h1F, 1'b1, 8'd3, 1'b1);
        step_b("t6_sat6",    8'h3F, 1'b1, 8'd3, 1'b1);
        step_b("t6_sat7",    8'h7F, 1'b1, 8'd3, 1'b1);
        step_b("t6_sat8",    8'hFF, 1'b1, 8'd3, 1'b1);
        step_b("t6_drop0",   8'hFE, 1'b1, 8'd3, 1'b1);
        step_b("t6_sat9",    8'hFF, 1'b1, 8'd3, 1'b1);

        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        e = '{"t6_async_rst", 1'b0, 8'd0, 1'b0};
        compare(e.name, e, bus_b.o_irq, {6'b0, bus_b.o_event_count}, bus_b.o_busy);
        @(negedge clk);
        bus_b.i_status = '0;
        rst_n = 1'b1;

        repeat (3) @(posedge clk);
        #2;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: got %0d/%0d queued entries, expected 0/0", q_a.size(), q_b.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
